// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_pkg.sv
// Shared types and default constants for the nand3 BIST stage.
package gf180mcu_fd_sc_mcu9t5v0__bist_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } bist_state_e;

  localparam logic [15:0] DefMisrPoly = 16'h1021;
  localparam logic [15:0] DefLfsrPoly = 16'hB400;
  localparam logic [15:0] DefLfsrSeed = 16'hACE1;

  localparam logic ModeExh  = 1'b0;
  localparam logic ModeLfsr = 1'b1;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_misr.sv
// Left-shifting serial-input MISR; also exposes the value it will load next
// so the caller can judge the final signature on the capturing edge.
module gf180mcu_fd_sc_mcu9t5v0__bist_misr #(
  parameter int unsigned      SIG_W     = 16,
  parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(16'h1021)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             sin_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [SIG_W-1:0] sig_nxt_o
);

  logic [SIG_W-1:0] sig_q;

  // Next signature: shift, fold feedback polynomial, inject serial bit.
  always_comb begin
    sig_nxt_o = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(sin_i);
  end

  // Signature register; clear has priority over capture.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sig_q <= '0;
    end else if (clear_i) begin
      sig_q <= '0;
    end else if (en_i) begin
      sig_q <= sig_nxt_o;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_nand3.sv
// BIST stage around a nand3 cell: drives A1/A2/A3 from registers (exhaustive
// counter or LFSR), compacts ZN one cycle later into a MISR, reports PASS.
module gf180mcu_fd_sc_mcu9t5v0__bist_nand3
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
  parameter int unsigned       SIG_W     = 16,
  parameter logic [SIG_W-1:0]  MISR_POLY = SIG_W'(DefMisrPoly),
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(DefLfsrPoly),
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DefLfsrSeed),
  parameter int unsigned       RUN_LEN   = 64
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             MODE,
  input  logic [SIG_W-1:0] EXP_SIG,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  input  logic             ZN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIG
);

  localparam int unsigned NMax = (RUN_LEN > 8) ? RUN_LEN : 8;
  // One spare bit so the counter can never wrap within a run.
  localparam int unsigned CntW = $clog2(NMax) + 1;

  if (LFSR_W < 3) begin : g_bad_lfsr_w
    $error("LFSR_W must be at least 3");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end
  if (RUN_LEN < 1) begin : g_bad_run_len
    $error("RUN_LEN must be at least 1");
  end

  bist_state_e       state_q, state_d;
  logic              mode_q, mode_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_nxt, cnt_last;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [2:0]        vec_q, vec_d;
  logic              pass_q, pass_d;
  logic              misr_clr, misr_en;
  logic [SIG_W-1:0]  sig, sig_nxt;

  // Pattern generator step values and the index of the final vector.
  always_comb begin
    lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
    cnt_nxt  = cnt_q + CntW'(1);
    cnt_last = (mode_q == ModeLfsr) ? CntW'(RUN_LEN - 1) : CntW'(7);
  end

  // Next-state logic: idle/done accept START, run applies one vector per cycle.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    vec_d    = vec_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          state_d  = StRun;
          mode_d   = MODE;
          cnt_d    = '0;
          lfsr_d   = LFSR_SEED;
          vec_d    = (MODE == ModeLfsr) ? LFSR_SEED[2:0] : 3'b000;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
        end
      end
      StRun: begin
        misr_en = 1'b1;
        cnt_d   = cnt_nxt;
        lfsr_d  = lfsr_nxt;
        if (cnt_q == cnt_last) begin
          state_d = StDone;
          vec_d   = 3'b000;
          pass_d  = (sig_nxt == EXP_SIG);
        end else begin
          vec_d = (mode_q == ModeLfsr) ? lfsr_nxt[2:0] : cnt_nxt[2:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      lfsr_q  <= '0;
      vec_q   <= 3'b000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
    end
  end

  gf180mcu_fd_sc_mcu9t5v0__bist_misr #(
    .SIG_W     (SIG_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .CLK       (CLK),
    .RN        (RN),
    .clear_i   (misr_clr),
    .en_i      (misr_en),
    .sin_i     (ZN),
    .sig_o     (sig),
    .sig_nxt_o (sig_nxt)
  );

  assign A1   = vec_q[0];
  assign A2   = vec_q[1];
  assign A3   = vec_q[2];
  assign BUSY = (state_q == StRun);
  assign DONE = (state_q == StDone);
  assign PASS = pass_q;
  assign SIG  = sig;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__bist_nand3.md
Name: gf180mcu_fd_sc_mcu9t5v0__bist_nand3

Overview:
- Self-contained built-in self-test stage that drives the three inputs of a nand3 cell under test (CUT) and compacts its ZN output into a signature.
- Sits directly around the CUT in the library qualification and characterisation harness:
  - upstream side: pattern source feeding A1/A2/A3;
  - downstream side: MISR consuming ZN.
- Supports an exhaustive mode (8 vectors) and a pseudo-random LFSR mode, and reports pass/fail against an expected signature.

Parameters:
- SIG_W, 16, MISR width.
- MISR_POLY, 16'h1021, MISR feedback polynomial, left-shifting.
- LFSR_W, 16, pattern LFSR width; must be at least 3.
- LFSR_POLY, 16'hB400, Galois feedback taps, right-shifting.
- LFSR_SEED, 16'hACE1, LFSR start value; must be nonzero (elaboration-time check).
- RUN_LEN, 64, number of vectors applied in LFSR mode; must be at least 1.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous, active-low reset.
- START  input  1  begin a test run; sampled on CLK.
- MODE  input  1  0 = exhaustive, 1 = LFSR; sampled only with START.
- EXP_SIG  input  SIG_W  expected signature; must be stable while BUSY is high.
- A1  output  1  CUT input, vec[0].
- A2  output  1  CUT input, vec[1].
- A3  output  1  CUT input, vec[2].
- ZN  input  1  CUT output.
- BUSY  output  1  high while patterns are being applied.
- DONE  output  1  run complete; held high until the next START.
- PASS  output  1  SIG == EXP_SIG; valid only while DONE is high.
- SIG  output  SIG_W  current MISR contents.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low, on ports CLK and RN.
  - RN low forces state IDLE and clears every register.
  - While in reset, all of A1/A2/A3, BUSY, DONE, PASS and SIG are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - A* = 0 and BUSY = 0.
  - START = 1 moves the FSM to RUN and latches MODE.
  - The same transition clears SIG, DONE and PASS, sets the pattern counter to 0 and loads the LFSR with LFSR_SEED.
- Pattern source:
  - A* come directly from registers; there is no combinational path from any input to A*.
  - Exhaustive mode: vec = 3-bit counter stepping 0,1,...,7; N = 8 vectors.
  - LFSR mode: vec = lfsr[2:0], N = RUN_LEN vectors.
  - LFSR update: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 0).
- Capture timing (one-cycle latency):
  - The vector applied after edge k is captured from ZN at edge k+1.
  - Edge k+1 also advances vec.
  - BUSY is high for exactly N cycles.
- MISR update on each capture edge: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ ZN.
- Completion and the DONE state:
  - The edge that captures the N-th vector moves the FSM to DONE, sets DONE = 1 and BUSY = 0, and drives A* = 0.
  - The same edge registers PASS = (next sig == EXP_SIG).
  - START to DONE rising: exactly N cycles.
  - SIG and PASS are frozen while in DONE.
  - START while in DONE behaves exactly as START from IDLE: the run restarts and DONE/PASS clear on that edge.
- START while in RUN is ignored; MODE changes while in RUN are ignored.
- RN asserted mid-run aborts the run immediately; no partial result is retained.
- The pattern counter is log2(max(8, RUN_LEN)) + 1 bits wide; wrap-around is impossible within one run.

Decomposition:
- Package gf180mcu_fd_sc_mcu9t5v0__bist_pkg holds:
  - the FSM state enum;
  - the default MISR_POLY, LFSR_POLY and LFSR_SEED constants;
  - the mode encoding constants.
- One sub-module, gf180mcu_fd_sc_mcu9t5v0__bist_misr: the parameterised MISR, with inputs CLK, RN, clear, enable, serial in, and output sig.
- The LFSR and the counter stay inline in the top module.

Test Plan:
- Reset, then pulse START with MODE = 0 and an ideal nand3 model connected:
  - A3A2A1 steps 000 through 111, one vector per cycle, and BUSY is high for 8 cycles;
  - DONE then rises with SIG = 16'h00FE;
  - with EXP_SIG = 16'h00FE, PASS = 1.
- Same run with ZN stuck at 1 → SIG = 16'h00FF, and PASS = 0 with EXP_SIG = 16'h00FE.
- Same run with ZN stuck at 0 → SIG = 16'h0000, PASS = 0.
- MODE = 1, RUN_LEN = 64:
  - the first three vec values are 3'b001, 3'b000, 3'b000 (A1 = lfsr[0], starting from seed 16'hACE1);
  - BUSY is high for exactly 64 cycles;
  - SIG matches the golden reference model.
- START pulsed mid-RUN → ignored, with timing unchanged. RN dropped at cycle 4 of RUN → all outputs 0 asynchronously.
  - A new START after reset gives a clean 16'h00FE run.
- Back-to-back runs: START while in DONE → DONE/PASS clear on that edge and the second run reproduces the identical signature.
